// File: rtl/hls_macc_obf_pkg.sv
// Shared constants for the key-locked vector MAC: one-hot state encoding, key-bit map, locked constants.
// STORED is what silicon holds; only STORED ^ GOLDEN_KEY recovers INTENDED.
package hls_macc_obf_pkg;

   typedef enum logic [3:0] {
      S_IDLE = 4'b0001,
      S_ACC  = 4'b0010,
      S_FIN  = 4'b0100,
      S_DONE = 4'b1000
   } state_e;

   localparam int ST_IDLE = 0;
   localparam int ST_ACC  = 1;
   localparam int ST_FIN  = 2;
   localparam int ST_DONE = 3;

   // Key-bit positions of the locked constants
   localparam int KB_ST    = 0;
   localparam int KB_DONE  = 4;
   localparam int KB_READY = 5;
   localparam int KB_VLD   = 6;
   localparam int KB_IDLE  = 7;
   localparam int KB_SEL   = 8;
   localparam int KB_CLR   = 9;
   localparam int KB_OFF   = 10;

   localparam int LOCK_W = 64;

   // State compares and drive values all 1, both polarities 0, OFFSET = 16
   localparam logic [LOCK_W-1:0] INTENDED   = 64'h0000_0000_0000_40FF;
   localparam logic [LOCK_W-1:0] GOLDEN_KEY = 64'hA5C3_9E17_5B2D_E4F1;
   localparam logic [LOCK_W-1:0] STORED     = INTENDED ^ GOLDEN_KEY;

endpackage

// File: rtl/hls_macc_obf_vec_if.sv
// ap_ctrl_hs control, operand bus and result for the key-locked vector MAC.
// master drives start/operands/key, slave returns handshake pulses and result.
interface hls_macc_obf_vec_if #(
   parameter int DATA_W  = 32,
   parameter int N_LANES = 4,
   parameter int ACC_W   = 68,
   parameter int KEY_W   = 64
);
   logic                      ap_start;
   logic                      ap_done;
   logic                      ap_idle;
   logic                      ap_ready;
   logic                      acc_clear;
   logic [N_LANES*DATA_W-1:0] a_flat;
   logic [N_LANES*DATA_W-1:0] b_flat;
   logic [DATA_W-1:0]         bias;
   logic [DATA_W-1:0]         cmp_a;
   logic [DATA_W-1:0]         cmp_b;
   logic [ACC_W-1:0]          result;
   logic                      result_ap_vld;
   logic [KEY_W-1:0]          locking_key;

   modport master (
      output ap_start, acc_clear, a_flat, b_flat, bias, cmp_a, cmp_b, locking_key,
      input  ap_done, ap_idle, ap_ready, result, result_ap_vld
   );

   modport slave (
      input  ap_start, acc_clear, a_flat, b_flat, bias, cmp_a, cmp_b, locking_key,
      output ap_done, ap_idle, ap_ready, result, result_ap_vld
   );
endinterface

// File: rtl/hls_macc_obf_lane.sv
// Time-shared MAC slice: registered signed multiply whose product is added to the running sum.
// Product lands one cycle after its operands; i_en low flushes the product register to zero.
module hls_macc_obf_lane #(
   parameter int DATA_W = 32,
   parameter int ACC_W  = 68
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_en,
   input  logic signed [DATA_W-1:0] i_a,
   input  logic signed [DATA_W-1:0] i_b,
   input  logic signed [ACC_W-1:0]  i_acc,
   output logic signed [ACC_W-1:0]  o_sum
);
   logic signed [2*DATA_W-1:0] r_prod;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_prod <= '0;
      end else if (i_en) begin
         r_prod <= (2*DATA_W)'(i_a) * (2*DATA_W)'(i_b);
      end else begin
         r_prod <= '0;
      end
   end

   assign o_sum = i_acc + ACC_W'(r_prod);

endmodule

// File: rtl/hls_macc_obf_vec.sv
// Key-locked vector dot product + bias/select, ap_ctrl_hs; start->done N_LANES+2 cycles, 1 IDLE cycle between runs.
// No backpressure: ap_start is only sampled in IDLE and the result is held until the next FIN.
module hls_macc_obf_vec
   import hls_macc_obf_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int N_LANES = 4,
   parameter int ACC_W   = 68,
   parameter int KEY_W   = 64
) (
   input  logic               i_ap_clk,
   input  logic               i_ap_rst_n,
   hls_macc_obf_vec_if.slave  s_bus
);
   localparam int IDX_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LANES - 1);
   localparam logic [KEY_W-1:0] STORED_K = KEY_W'(STORED);

   state_e                    r_state;
   logic [IDX_W-1:0]          r_idx;
   logic signed [ACC_W-1:0]   r_acc;
   logic signed [ACC_W-1:0]   r_result;
   logic [N_LANES*DATA_W-1:0] r_a;
   logic [N_LANES*DATA_W-1:0] r_b;
   logic signed [DATA_W-1:0]  r_bias;
   logic signed [DATA_W-1:0]  r_cmp_a;
   logic signed [DATA_W-1:0]  r_cmp_b;
   logic                      r_done;
   logic                      r_ready;
   logic                      r_vld;

   logic [KEY_W-1:0]          w_k;
   logic                      w_in_idle;
   logic                      w_in_acc;
   logic                      w_in_fin;
   logic                      w_in_done;
   logic                      w_clr;
   logic                      w_sel;
   logic signed [DATA_W-1:0]  w_off;
   logic signed [DATA_W-1:0]  w_op_a;
   logic signed [DATA_W-1:0]  w_op_b;
   logic signed [ACC_W-1:0]   w_sum;
   logic signed [ACC_W-1:0]   w_fin;

   // A wrong key silently corrupts every decoded constant below
   assign w_k = STORED_K ^ s_bus.locking_key;

   if (KEY_W > KB_OFF + DATA_W) begin : g_spare_key
      wire w_unused_key_hi = ^w_k[KEY_W-1:KB_OFF+DATA_W];
   end

   assign w_in_idle = (r_state[ST_IDLE] == w_k[KB_ST+ST_IDLE]);
   assign w_in_acc  = (r_state[ST_ACC]  == w_k[KB_ST+ST_ACC]);
   assign w_in_fin  = (r_state[ST_FIN]  == w_k[KB_ST+ST_FIN]);
   assign w_in_done = (r_state[ST_DONE] == w_k[KB_ST+ST_DONE]);

   assign w_clr  = s_bus.acc_clear ^ w_k[KB_CLR];
   assign w_sel  = (r_cmp_a < r_cmp_b) ^ w_k[KB_SEL];
   assign w_off  = w_k[KB_OFF +: DATA_W];
   assign w_op_a = r_a[r_idx*DATA_W +: DATA_W];
   assign w_op_b = r_b[r_idx*DATA_W +: DATA_W];

   hls_macc_obf_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_lane (
      .i_clk   (i_ap_clk),
      .i_rst_n (i_ap_rst_n),
      .i_en    (w_in_acc),
      .i_a     (w_op_a),
      .i_b     (w_op_b),
      .i_acc   (r_acc),
      .o_sum   (w_sum)
   );

   // In FIN w_sum already folds in the last lane's product
   assign w_fin = w_sel ? (w_sum + ACC_W'(r_bias) + ACC_W'(w_off))
                        : (w_sum - ACC_W'(r_bias));

   always_ff @(posedge i_ap_clk) begin
      if (!i_ap_rst_n) begin
         r_state  <= S_IDLE;
         r_idx    <= '0;
         r_acc    <= '0;
         r_result <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_bias   <= '0;
         r_cmp_a  <= '0;
         r_cmp_b  <= '0;
         r_done   <= 1'b0;
         r_ready  <= 1'b0;
         r_vld    <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_ready <= 1'b0;
         r_vld   <= 1'b0;
         if (w_in_idle) begin
            if (s_bus.ap_start) begin
               r_a     <= s_bus.a_flat;
               r_b     <= s_bus.b_flat;
               r_bias  <= s_bus.bias;
               r_cmp_a <= s_bus.cmp_a;
               r_cmp_b <= s_bus.cmp_b;
               r_idx   <= '0;
               if (w_clr) begin
                  r_acc <= '0;
               end
               r_state <= S_ACC;
            end
         end else if (w_in_acc) begin
            r_acc <= w_sum;
            r_idx <= r_idx + 1'b1;
            if (r_idx == LAST_IDX) begin
               r_state <= S_FIN;
            end
         end else if (w_in_fin) begin
            r_acc    <= w_sum;
            r_result <= w_fin;
            r_done   <= w_k[KB_DONE];
            r_ready  <= w_k[KB_READY];
            r_vld    <= w_k[KB_VLD];
            r_state  <= S_DONE;
         end else begin
            // DONE, or an undecodable state under a wrong key
            r_state <= S_IDLE;
         end
      end
   end

   assign s_bus.ap_done       = r_done;
   assign s_bus.ap_ready      = r_ready;
   assign s_bus.result_ap_vld = r_vld;
   assign s_bus.result        = r_result;
   assign s_bus.ap_idle       = w_in_idle & ~s_bus.ap_start & w_k[KB_IDLE];

endmodule
